// File: rtl/clk_divider_pkg.sv
// Shared constants and types for the fixed /2 and /4 clock divider.
package clk_divider_pkg;

    localparam int unsigned CNT_W = 2;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage : clk_divider_pkg

// File: rtl/clk_divider_if.sv
// Divided-clock outputs bundled for connection between divider and consumers.
interface clk_divider_if;

    logic div2_clk;
    logic div4_clk;

    modport master (
        output div2_clk,
        output div4_clk
    );

    modport slave (
        input div2_clk,
        input div4_clk
    );

endinterface : clk_divider_if

// File: rtl/clk_divider.sv
// Free-running 2-bit counter; bit 0 is clk/2 and bit 1 is clk/4, both taken straight from flops.
module clk_divider
    import clk_divider_pkg::*;
(
    input  logic          clk,
    input  logic          resetn,
    clk_divider_if.master div_if
);

    cnt_t cnt;

    // resetn is active-high here: a 1 sampled on a rising edge clears the counter
    always_ff @(posedge clk) begin
        if (resetn) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign div_if.div2_clk = cnt[0];
    assign div_if.div4_clk = cnt[1];

endmodule : clk_divider

// File: tb/tb_clk_divider.sv
// Self-checking bench for clk_divider against an edge-count reference model.
module tb_clk_divider;

    logic clk;
    logic resetn;
    int   n_tests;
    int   n_fail;
    int   k;

    clk_divider_if dif ();

    clk_divider dut (
        .clk    (clk),
        .resetn (resetn),
        .div_if (dif.master)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    // Model: k = rising edges seen since the last reset edge
    function automatic logic exp_div2(input int kk);
        return logic'(kk % 2);
    endfunction

    function automatic logic exp_div4(input int kk);
        return logic'((kk % 4) / 2);
    endfunction

    // Drive resetn, let one rising edge happen, sample at the following falling edge
    task automatic step(input logic r);
        resetn = r;
        @(posedge clk);
        if (r) k = 0;
        else   k = k + 1;
        @(negedge clk);
    endtask

    task automatic check_model(input string name);
        n_tests++;
        if (dif.div2_clk !== exp_div2(k) || dif.div4_clk !== exp_div4(k)) begin
            n_fail++;
            $display("FAIL %s k=%0d: got div2=%b div4=%b, expected div2=%b div4=%b",
                     name, k, dif.div2_clk, dif.div4_clk, exp_div2(k), exp_div4(k));
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            n_tests++;
            if (dif.div2_clk !== 1'b0 || dif.div4_clk !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold edge %0d: got div2=%b div4=%b, expected 0 0",
                         i, dif.div2_clk, dif.div4_clk);
            end
        end
    endtask

    task automatic check_release_seq(input string name);
        logic [7:0] seq2;
        logic [7:0] seq4;
        seq2 = 8'b10101010;
        seq4 = 8'b01100110;
        for (int i = 0; i < 8; i++) begin
            step(1'b0);
            n_tests++;
            if (dif.div2_clk !== seq2[7-i] || dif.div4_clk !== seq4[7-i]) begin
                n_fail++;
                $display("FAIL %s edge %0d: got div2=%b div4=%b, expected div2=%b div4=%b",
                         name, i + 1, dif.div2_clk, dif.div4_clk, seq2[7-i], seq4[7-i]);
            end
        end
    endtask

    task automatic test_release();
        step(1'b1);
        check_release_seq("release");
    endtask

    // Rise counts, high times and phase relation over 4000 free-running cycles
    task automatic test_freq_duty_phase();
        int    rise2;
        int    rise4;
        logic  p2;
        logic  p4;
        time   t2;
        time   t4;
        step(1'b1);
        rise2 = 0;
        rise4 = 0;
        p2 = dif.div2_clk;
        p4 = dif.div4_clk;
        t2 = $time;
        t4 = $time;
        for (int i = 0; i < 4000; i++) begin
            step(1'b0);
            if (i % 97 == 0) check_model("free_run");
            if (!p2 && dif.div2_clk) begin
                rise2++;
                t2 = $time;
            end
            if (p2 && !dif.div2_clk) begin
                n_tests++;
                if ($time - t2 != 2) begin
                    n_fail++;
                    $display("FAIL div2_high_time: got %0t, expected 2", $time - t2);
                end
            end
            if (!p4 && dif.div4_clk) begin
                rise4++;
                t4 = $time;
            end
            if (p4 && !dif.div4_clk) begin
                n_tests++;
                if ($time - t4 != 4) begin
                    n_fail++;
                    $display("FAIL div4_high_time: got %0t, expected 4", $time - t4);
                end
            end
            if (p4 !== dif.div4_clk) begin
                n_tests++;
                if (!(p2 === 1'b1 && dif.div2_clk === 1'b0)) begin
                    n_fail++;
                    $display("FAIL phase_div4_toggle: div2 went %b->%b, expected 1->0",
                             p2, dif.div2_clk);
                end
            end
            p2 = dif.div2_clk;
            p4 = dif.div4_clk;
        end
        n_tests++;
        if (rise2 != 2000) begin
            n_fail++;
            $display("FAIL div2_rise_count: got %0d, expected 2000", rise2);
        end
        n_tests++;
        if (rise4 != 1000) begin
            n_fail++;
            $display("FAIL div4_rise_count: got %0d, expected 1000", rise4);
        end
    endtask

    task automatic run_until_both_high(input string name);
        int guard;
        guard = 0;
        while (!(dif.div2_clk === 1'b1 && dif.div4_clk === 1'b1) && guard < 8) begin
            step(1'b0);
            guard++;
        end
        n_tests++;
        if (dif.div2_clk !== 1'b1 || dif.div4_clk !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_reach_11: got div2=%b div4=%b after %0d edges, expected 1 1",
                     name, dif.div2_clk, dif.div4_clk, guard);
        end
    endtask

    task automatic test_midrun_reset();
        step(1'b1);
        for (int i = 0; i < int'($urandom_range(0, 5)); i++) step(1'b0);
        run_until_both_high("midrun");
        step(1'b1);
        n_tests++;
        if (dif.div2_clk !== 1'b0 || dif.div4_clk !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: got div2=%b div4=%b, expected 0 0",
                     dif.div2_clk, dif.div4_clk);
        end
        check_release_seq("midrun_release");
    endtask

    task automatic test_wrap();
        step(1'b1);
        run_until_both_high("wrap");
        step(1'b0);
        n_tests++;
        if (dif.div2_clk !== 1'b0 || dif.div4_clk !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_to_00: got div2=%b div4=%b, expected 0 0",
                     dif.div2_clk, dif.div4_clk);
        end
        step(1'b0);
        n_tests++;
        if (dif.div2_clk !== 1'b1 || dif.div4_clk !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_next: got div2=%b div4=%b, expected 1 0",
                     dif.div2_clk, dif.div4_clk);
        end
    endtask

    task automatic test_random_reset();
        for (int i = 0; i < 400; i++) begin
            step(logic'($urandom_range(0, 9) == 0));
            check_model("random");
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        k       = 0;
        resetn  = 1'b1;
        @(negedge clk);
        test_reset();
        test_release();
        test_freq_duty_phase();
        test_midrun_reset();
        test_wrap();
        test_random_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_clk_divider
